uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
Receive-side controller for the UART receiver. It sits between the synchronized serial line and the team's flexible serial-to-parallel shift register. It detects start bits, times bit centres, and strobes the shift register's shift enable. It then consumes the register's parallel word, checks the stop bit, and presents the byte to the system through a ready/read handshake with framing and overrun flags.

Parameters:
CLKS_PER_BIT, 10, clock cycles per serial bit; even, >= 4
DATA_BITS, 8, data bits per frame; shift register is DATA_BITS+1 wide

Ports:
clk  input  1  system clock
n_rst  input  1  reset; one clock; reset is asynchronous and active-high
serial_in  input  1  synchronized receive line, idle high
sr_data  input  DATA_BITS+1  shift register parallel output; [DATA_BITS]=stop bit, [DATA_BITS-1:0]=data, bit 0 first received
data_read  input  1  consumer has taken rx_data (level, sampled each cycle)
sr_shift_en  output  1  one-cycle strobe at each bit centre, to the shift register
rx_data  output  DATA_BITS  received byte
data_ready  output  1  rx_data holds an unread byte
framing_error  output  1  last frame had stop bit = 0
overrun_error  output  1  new byte arrived while data_ready=1
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (any time, including mid-frame): FSM=IDLE, counters=0, sr_shift_en=0, rx_data=all ones, data_ready=0, framing_error=0, overrun_error=0, busy=0.
- Edge detect: registered copy of serial_in (resets to 1). Start condition = prev 1, current 0.
- IDLE: start condition -> START_CHK, timer=0.
- START_CHK: timer counts up. At timer==CLKS_PER_BIT/2-1, sample serial_in.
  - If 0 -> RECV, timer=0, bit_cnt=0.
  - If 1 -> IDLE. Glitch: no strobe, no flag change.
- RECV: timer counts 0..CLKS_PER_BIT-1 and wraps.
  - At timer==CLKS_PER_BIT-1, sr_shift_en=1 for exactly that cycle and bit_cnt increments.
  - After the (DATA_BITS+1)th strobe -> STOP_CHK.
- STOP_CHK (1 cycle): sr_data is now the complete frame.
  - sr_data[DATA_BITS]==0: framing_error<=1, no load, -> IDLE.
  - Otherwise: framing_error<=0, -> LOAD.
- LOAD (1 cycle):
  - rx_data<=sr_data[DATA_BITS-1:0] and data_ready<=1.
  - If data_ready was 1 and data_read=0 this cycle, overrun_error<=1; previous byte is overwritten.
  - -> IDLE.
- data_read=1 outside LOAD: data_ready<=0 and overrun_error<=0 next cycle. Otherwise these outputs hold.
- data_read=1 during LOAD: load wins; data_ready stays 1, no overrun.
- framing_error holds until the next frame reaches STOP_CHK.
- Start conditions during START_CHK, RECV, STOP_CHK or LOAD are ignored.
- Latency: let T0 be the clock edge at which the start condition is registered. data_ready rises at T0 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT + 2, which is 97 cycles for the defaults.
- Timer width: $clog2(CLKS_PER_BIT). bit_cnt width: $clog2(DATA_BITS+2). No counter overflows within a frame.

Decomposition:
- Package uart_rx_pkg:
  - state enum: IDLE, START_CHK, RECV, STOP_CHK, LOAD
  - default CLKS_PER_BIT and DATA_BITS constants
  - timer/bit-count width localparams
- One sub-module, rx_bit_timer, built as a parameterized rollover counter with enable and clear:
  - outputs the half-bit and full-bit strobes and bit_cnt
  - the FSM, edge detect and output registers stay in uart_rx_ctrl

Test Plan:
The bench instantiates the team shift register, NUM_BITS=DATA_BITS+1, LSB-first, enabled by sr_shift_en. Defaults are used throughout.
1. Frame 0xA5, stop=1 -> 9 sr_shift_en pulses spaced 10 cycles, first at T0+15; data_ready=1 at T0+97; rx_data=0xA5; both error flags 0.
2. serial_in low for 3 cycles, then high -> returns to IDLE; no sr_shift_en, busy low by T0+6, flags unchanged.
3. Frame 0x3C with stop=0 -> framing_error=1 at T0+96; data_ready stays 0; rx_data keeps its prior value. A following valid 0x11 frame clears framing_error and loads 0x11.
4. Frames 0x12 then 0x34 with no data_read -> rx_data=0x34, overrun_error=1. data_read pulse -> data_ready=0, overrun_error=0 next cycle.
5. data_read asserted exactly in the LOAD cycle of the second frame -> data_ready=1, overrun_error=0, rx_data=second byte.
6. n_rst asserted mid-RECV (after 4 strobes) -> all outputs at reset values immediately. A following frame 0x5A is received correctly with data_ready at T0+97.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and sizing for the UART receive controller and its bit timer.
package uart_rx_pkg;

    localparam int CLKS_PER_BIT_DEF = 10;
    localparam int DATA_BITS_DEF    = 8;

    // Minimum counter width able to index 0..max_count-1, never below one bit.
    function automatic int cnt_width(input int max_count);
        return (max_count <= 32'sd2) ? 32'sd1 : $clog2(max_count);
    endfunction

    localparam int TIMER_W_DEF   = cnt_width(CLKS_PER_BIT_DEF);
    localparam int BIT_CNT_W_DEF = cnt_width(DATA_BITS_DEF + 2);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_CHK = 3'd1,
        RECV      = 3'd2,
        STOP_CHK  = 3'd3,
        LOAD      = 3'd4
    } rx_state_e;

endpackage

// File: rtl/rx_bit_timer.sv
// Rollover bit-period counter: half-bit and full-bit strobes plus a count of
// completed bit periods. Clear has priority over enable.
module rx_bit_timer
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int TIMER_W      = TIMER_W_DEF,
    parameter int CNT_W        = BIT_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    output logic             half,
    output logic             full,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam logic [TIMER_W-1:0] HALF_LAST = TIMER_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TIMER_W-1:0] FULL_LAST = TIMER_W'(CLKS_PER_BIT - 1);

    logic [TIMER_W-1:0] timer_r;
    logic [CNT_W-1:0]   bit_cnt_r;

    // Timer wraps at the last clock of a bit; each wrap counts one bit period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_r   <= '0;
            bit_cnt_r <= '0;
        end else if (clear) begin
            timer_r   <= '0;
            bit_cnt_r <= '0;
        end else if (en) begin
            if (timer_r == FULL_LAST) begin
                timer_r   <= '0;
                bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end else begin
                timer_r   <= timer_r + TIMER_W'(1);
            end
        end
    end

    assign half    = en && (timer_r == HALF_LAST);
    assign full    = en && (timer_r == FULL_LAST);
    assign bit_cnt = bit_cnt_r;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detection, bit-centre strobes to the external
// shift register, stop-bit check and a ready/read handshake with error flags.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int DATA_BITS    = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 serial_in,
    input  logic [DATA_BITS:0]   sr_data,
    input  logic                 data_read,
    output logic                 sr_shift_en,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 framing_error,
    output logic                 overrun_error,
    output logic                 busy
);

    localparam int TIMER_W = cnt_width(CLKS_PER_BIT);
    localparam int CNT_W   = cnt_width(DATA_BITS + 2);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS);

    rx_state_e            state_r;
    rx_state_e            state_next_s;
    logic                 prev_r;
    logic                 start_cond_s;
    logic                 tmr_clear_s;
    logic                 tmr_en_s;
    logic                 half_s;
    logic                 full_s;
    logic [CNT_W-1:0]     bit_cnt_s;
    logic                 shift_s;
    logic [DATA_BITS-1:0] rx_data_r;
    logic                 data_ready_r;
    logic                 framing_r;
    logic                 overrun_r;
    logic                 busy_r;

    rx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .TIMER_W      (TIMER_W),
        .CNT_W        (CNT_W)
    ) u_bit_timer (
        .clk     (clk),
        .rst     (n_rst),
        .clear   (tmr_clear_s),
        .en      (tmr_en_s),
        .half    (half_s),
        .full    (full_s),
        .bit_cnt (bit_cnt_s)
    );

    assign start_cond_s = prev_r & ~serial_in;

    // State register and line history; the history idles high so reset never looks like a start.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            state_r <= IDLE;
            prev_r  <= 1'b1;
        end else begin
            state_r <= state_next_s;
            prev_r  <= serial_in;
        end
    end

    // Next-state and timer control; the timer is held clear whenever it is not timing.
    always_comb begin
        state_next_s = state_r;
        tmr_clear_s  = 1'b0;
        tmr_en_s     = 1'b0;
        shift_s      = 1'b0;
        case (state_r)
            IDLE: begin
                tmr_clear_s = 1'b1;
                if (start_cond_s) begin
                    state_next_s = START_CHK;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START_CHK: begin
                tmr_en_s = 1'b1;
                if (half_s) begin
                    tmr_clear_s = 1'b1;
                    if (serial_in) begin
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = RECV;
                    end
                end else begin
                    state_next_s = START_CHK;
                end
            end
            RECV: begin
                tmr_en_s = 1'b1;
                if (full_s) begin
                    shift_s = 1'b1;
                    if (bit_cnt_s == LAST_BIT) begin
                        state_next_s = STOP_CHK;
                    end else begin
                        state_next_s = RECV;
                    end
                end else begin
                    state_next_s = RECV;
                end
            end
            STOP_CHK: begin
                tmr_clear_s = 1'b1;
                if (sr_data[DATA_BITS]) begin
                    state_next_s = LOAD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD: begin
                tmr_clear_s  = 1'b1;
                state_next_s = IDLE;
            end
            default: begin
                tmr_clear_s  = 1'b1;
                state_next_s = IDLE;
            end
        endcase
    end

    // Output holding registers; a load in the same cycle as a read keeps the new byte pending.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            rx_data_r    <= '1;
            data_ready_r <= 1'b0;
            framing_r    <= 1'b0;
            overrun_r    <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            busy_r <= (state_next_s != IDLE);
            if (state_r == STOP_CHK) begin
                framing_r <= ~sr_data[DATA_BITS];
            end
            if (state_r == LOAD) begin
                rx_data_r    <= sr_data[DATA_BITS-1:0];
                data_ready_r <= 1'b1;
                if (data_ready_r && !data_read) begin
                    overrun_r <= 1'b1;
                end
            end else if (data_read) begin
                data_ready_r <= 1'b0;
                overrun_r    <= 1'b0;
            end
        end
    end

    assign sr_shift_en   = shift_s;
    assign rx_data       = rx_data_r;
    assign data_ready    = data_ready_r;
    assign framing_error = framing_r;
    assign overrun_error = overrun_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl with an LSB-first shift register and a frame-timing model.
module tb_uart_rx_ctrl;

    localparam int CPB    = 10;
    localparam int DB     = 8;
    localparam int HALF   = CPB / 2;
    localparam int FE_K   = HALF + (DB + 1) * CPB + 1;
    localparam int LOAD_K = FE_K + 1;

    logic          clk = 1'b0;
    logic          n_rst = 1'b1;
    logic          serial_in = 1'b1;
    logic          data_read = 1'b0;
    logic [DB:0]   sr;
    logic          sr_shift_en;
    logic [DB-1:0] rx_data;
    logic          data_ready;
    logic          framing_error;
    logic          overrun_error;
    logic          busy;

    uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .serial_in     (serial_in),
        .sr_data       (sr),
        .data_read     (data_read),
        .sr_shift_en   (sr_shift_en),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .framing_error (framing_error),
        .overrun_error (overrun_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Serial-to-parallel register: newest bit enters at the top, first bit ends at bit 0.
    always @(posedge clk or posedge n_rst) begin
        if (n_rst) sr <= '1;
        else if (sr_shift_en) sr <= {serial_in, sr[DB:1]};
    end

    // Description of the frame currently on the line.
    int            f_t0 = -1000;
    logic          f_active = 1'b0;
    logic          f_glitch = 1'b0;
    logic          f_stop = 1'b1;
    logic [DB-1:0] f_byte = '0;

    logic          m_dr;
    logic [DB-1:0] m_rx;
    logic          m_fe;
    logic          m_oe;

    // Expected handshake state: stop-bit verdict FE_K edges after T0, byte load one edge later.
    always @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            m_dr <= 1'b0;
            m_rx <= '1;
            m_fe <= 1'b0;
            m_oe <= 1'b0;
        end else begin
            if (f_active && !f_glitch && (cyc + 1 - f_t0) == FE_K) m_fe <= !f_stop;
            if (f_active && !f_glitch && f_stop && (cyc + 1 - f_t0) == LOAD_K) begin
                m_rx <= f_byte;
                m_dr <= 1'b1;
                if (m_dr && !data_read) m_oe <= 1'b1;
            end else if (data_read) begin
                m_dr <= 1'b0;
                m_oe <= 1'b0;
            end
        end
    end

    logic          pin_en = 1'b0;
    string         pin_name = "";
    logic [DB-1:0] pin_rx = '0;
    logic          pin_dr = 1'b0;
    logic          pin_fe = 1'b0;
    logic          pin_oe = 1'b0;
    logic          pin_busy = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    initial begin : compare
        int   k;
        int   s;
        logic e_busy;
        logic e_shift;
        forever begin
            @(negedge clk);
            k = cyc - f_t0;
            s = k + 1 - HALF;
            e_busy = f_active && k >= 0 &&
                     k <= (f_glitch ? HALF - 1 : (f_stop ? LOAD_K - 1 : FE_K - 1));
            e_shift = f_active && !f_glitch && s >= CPB && s <= (DB + 1) * CPB && (s % CPB) == 0;
            n_checks++;
            if ({data_ready, rx_data, framing_error, overrun_error, busy, sr_shift_en} !==
                {m_dr, m_rx, m_fe, m_oe, e_busy, e_shift}) begin
                n_fail++;
                $display("FAIL cycle_%0d k=%0d: got dr=%b rx=%h fe=%b oe=%b busy=%b shift=%b, want dr=%b rx=%h fe=%b oe=%b busy=%b shift=%b",
                         cyc, k, data_ready, rx_data, framing_error, overrun_error, busy, sr_shift_en,
                         m_dr, m_rx, m_fe, m_oe, e_busy, e_shift);
            end
            if (pin_en) begin
                n_checks++;
                if ({rx_data, data_ready, framing_error, overrun_error, busy} !==
                    {pin_rx, pin_dr, pin_fe, pin_oe, pin_busy}) begin
                    n_fail++;
                    $display("FAIL %s: got rx=%h dr=%b fe=%b oe=%b busy=%b, want rx=%h dr=%b fe=%b oe=%b busy=%b",
                             pin_name, rx_data, data_ready, framing_error, overrun_error, busy,
                             pin_rx, pin_dr, pin_fe, pin_oe, pin_busy);
                end
            end
        end
    end

    task automatic set_pins(input string name, input logic [DB-1:0] rx, input logic dr,
                            input logic fe, input logic oe, input logic bsy);
        pin_name = name;
        pin_rx   = rx;
        pin_dr   = dr;
        pin_fe   = fe;
        pin_oe   = oe;
        pin_busy = bsy;
        pin_en   = 1'b1;
    endtask

    task automatic pin_check(input string name, input logic [DB-1:0] rx, input logic dr,
                             input logic fe, input logic oe, input logic bsy);
        @(posedge clk);
        #1;
        set_pins(name, rx, dr, fe, oe, bsy);
        @(posedge clk);
        #1;
        pin_en = 1'b0;
    endtask

    task automatic read_pulse();
        @(negedge clk);
        data_read = 1'b1;
        @(negedge clk);
        data_read = 1'b0;
    endtask

    task automatic mid_frame_reset();
        serial_in = 1'b1;
        data_read = 1'b0;
        @(posedge clk);
        #2;
        n_rst    = 1'b1;
        f_active = 1'b0;
        set_pins("reset_mid_recv", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1;
        pin_en = 1'b0;
        @(negedge clk);
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // One frame, start edge registered at T0 = f_t0; each bit held CPB cycles.
    task automatic send_frame(input logic [DB-1:0] b, input logic stop,
                              input logic rd_at_load, input int rst_at);
        int idx;
        @(negedge clk);
        f_t0     = cyc + 1;
        f_byte   = b;
        f_stop   = stop;
        f_glitch = 1'b0;
        f_active = 1'b1;
        for (int c = 0; c < (DB + 2) * CPB + 4; c++) begin
            if (rst_at >= 0 && c == rst_at) begin
                mid_frame_reset();
                return;
            end
            idx = c / CPB;
            if (idx == 0) serial_in = 1'b0;
            else if (idx <= DB) serial_in = b[idx-1];
            else if (idx == DB + 1) serial_in = stop;
            else serial_in = 1'b1;
            data_read = rd_at_load && (c == LOAD_K);
            @(negedge clk);
        end
        data_read = 1'b0;
    endtask

    task automatic send_glitch();
        @(negedge clk);
        f_t0     = cyc + 1;
        f_glitch = 1'b1;
        f_active = 1'b1;
        serial_in = 1'b0;
        repeat (3) @(negedge clk);
        serial_in = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        pin_check("reset_values", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_rst = 1'b0;
        repeat (3) @(negedge clk);

        send_frame(8'hA5, 1'b1, 1'b0, -1);
        pin_check("frame_a5", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        read_pulse();
        pin_check("read_a5", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);

        send_glitch();
        pin_check("glitch_idle", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);

        send_frame(8'h3C, 1'b0, 1'b0, -1);
        pin_check("framing_3c", 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h11, 1'b1, 1'b0, -1);
        pin_check("frame_11_clears_fe", 8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
        read_pulse();
        pin_check("read_11", 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);

        send_frame(8'h12, 1'b1, 1'b0, -1);
        send_frame(8'h34, 1'b1, 1'b0, -1);
        pin_check("overrun_34", 8'h34, 1'b1, 1'b0, 1'b1, 1'b0);
        read_pulse();
        pin_check("read_clears_overrun", 8'h34, 1'b0, 1'b0, 1'b0, 1'b0);

        send_frame(8'h56, 1'b1, 1'b0, -1);
        pin_check("frame_56", 8'h56, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'h78, 1'b1, 1'b1, -1);
        pin_check("read_in_load_78", 8'h78, 1'b1, 1'b0, 1'b0, 1'b0);

        send_frame(8'h77, 1'b1, 1'b0, 50);
        send_frame(8'h5A, 1'b1, 1'b0, -1);
        pin_check("frame_5a_after_reset", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
